// File: rtl/timer_pkg.sv
// Shared constants for the timer_counter block: FSM state codes,
// register indices, CTRL bit positions and mode codes.
package timer_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_CNT  = 2'd2;
   localparam logic [1:0] ST_INT  = 2'd3;

   localparam logic [1:0] CTRL_IDX   = 2'd0;
   localparam logic [1:0] PRESET_IDX = 2'd1;
   localparam logic [1:0] COUNT_IDX  = 2'd2;

   localparam int CTRL_W   = 4;
   localparam int EN_BIT   = 0;
   localparam int MODE_LSB = 1;
   localparam int MODE_MSB = 2;
   localparam int IM_BIT   = 3;

   localparam logic [1:0] MODE_ONESHOT = 2'd0;
   localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage

// File: rtl/timer_counter.sv
// Programmable down-counter timer with one-shot and auto-reload modes.
// Ports: clk, rst_n (async low), We/Addr/WD register write,
// RD combinational register read, IRQ registered interrupt request.
module timer_counter
   import timer_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              We,
   input  logic [3:0]        Addr,
   input  logic [DATA_W-1:0] WD,
   output logic [DATA_W-1:0] RD,
   output logic              IRQ
);

   logic [CTRL_W-1:0] ctrl, ctrlNxt;
   logic [DATA_W-1:0] preset, presetNxt;
   logic [DATA_W-1:0] count, countNxt;
   logic [1:0]        state, stateNxt;
   logic              irqFlag, flagNxt;
   logic [1:0]        regSel;
   logic [1:0]        mode;
   logic              en;
   logic              unusedAddr;

   assign regSel     = Addr[3:2];
   assign unusedAddr = ^Addr[1:0];
   assign en         = ctrl[EN_BIT];
   assign mode       = ctrl[MODE_MSB:MODE_LSB];

   always_comb begin
      case (regSel)
         CTRL_IDX:   RD = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
         PRESET_IDX: RD = preset;
         COUNT_IDX:  RD = count;
         default:    RD = '0;
      endcase
   end

   // FSM decisions use the pre-write register values; a CPU write
   // to CTRL is applied last so it overrides the FSM's Enable clear.
   always_comb begin
      stateNxt  = state;
      countNxt  = count;
      ctrlNxt   = ctrl;
      presetNxt = preset;
      flagNxt   = irqFlag;
      case (state)
         ST_IDLE: begin
            if (en) stateNxt = ST_LOAD;
         end
         ST_LOAD: begin
            countNxt = preset;
            stateNxt = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               stateNxt = ST_IDLE;
            end else if (count > DATA_W'(1)) begin
               countNxt = count - DATA_W'(1);
            end else begin
               countNxt = '0;
               flagNxt  = 1'b1;
               stateNxt = ST_INT;
            end
         end
         default: begin
            // Reserved modes 2/3 fall through to one-shot.
            if (mode == MODE_RELOAD) begin
               flagNxt  = 1'b0;
               stateNxt = ST_LOAD;
            end else begin
               ctrlNxt[EN_BIT] = 1'b0;
               stateNxt        = ST_IDLE;
            end
         end
      endcase
      if (We) begin
         if (regSel == CTRL_IDX) begin
            ctrlNxt = WD[CTRL_W-1:0];
            flagNxt = 1'b0;
         end
         if (regSel == PRESET_IDX) presetNxt = WD;
      end
   end

   // IRQ is flopped from next-state values so it rises on the same
   // edge as the flag while keeping no combinational path from We.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl    <= '0;
         preset  <= '0;
         count   <= '0;
         state   <= ST_IDLE;
         irqFlag <= 1'b0;
         IRQ     <= 1'b0;
      end else begin
         ctrl    <= ctrlNxt;
         preset  <= presetNxt;
         count   <= countNxt;
         state   <= stateNxt;
         irqFlag <= flagNxt;
         IRQ     <= flagNxt & ctrlNxt[IM_BIT];
      end
   end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus
// randomized runs against a closed-form timing model.
module tb_timer_counter;

   logic        clk;
   logic        rst_n;
   logic        We;
   logic [3:0]  Addr;
   logic [31:0] WD;
   logic [31:0] RD;
   logic        IRQ;

   int nTests;
   int nFail;

   timer_counter #(.DATA_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .We   (We),
      .Addr (Addr),
      .WD   (WD),
      .RD   (RD),
      .IRQ  (IRQ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected COUNT/IRQ observed after edge E+k, where E is the edge
   // of the enabling CTRL write; old is COUNT before that write.
   function automatic void model(input int k, input int n,
                                 input int md, input bit im,
                                 input int old, output int cnt,
                                 output bit irq);
      int eff;
      int p;
      int j;
      eff = (n < 1) ? 1 : n;
      p   = eff + 2;
      irq = 1'b0;
      if (md == 1) begin
         j = (k - 1) % p;
         if (j == 0) cnt = (k == 1) ? old : 0;
         else if (j <= eff) cnt = n - (j - 1);
         else begin
            cnt = 0;
            irq = im;
         end
      end else begin
         if (k == 1) cnt = old;
         else if (k <= eff + 1) cnt = n - (k - 2);
         else begin
            cnt = 0;
            irq = im;
         end
      end
   endfunction

   task automatic wrReg(input logic [3:0] a, input logic [31:0] d);
      We   = 1'b1;
      Addr = a;
      WD   = d;
      @(posedge clk);
      #1;
      We   = 1'b0;
      Addr = 4'h8;
      WD   = '0;
   endtask

   task automatic readReg(input logic [3:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = RD;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   // Steps k=1..cycles after the enabling write, checking COUNT/IRQ.
   task automatic track(input string nm, input int n, input int md,
                        input bit im, input int old, input int cycles);
      int cnt;
      bit irq;
      logic [31:0] d;
      for (int k = 1; k <= cycles; k++) begin
         step();
         model(k, n, md, im, old, cnt, irq);
         readReg(4'h8, d);
         nTests++;
         if (d !== 32'(cnt)) begin
            nFail++;
            $display("FAIL %s count k=%0d got %0d exp %0d",
                     nm, k, d, cnt);
         end
         nTests++;
         if (IRQ !== irq) begin
            nFail++;
            $display("FAIL %s irq k=%0d got %b exp %b",
                     nm, k, IRQ, irq);
         end
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic [31:0] exp0;
      doReset();
      exp0 = '0;
      for (int a = 0; a < 3; a++) begin
         readReg(4'(a * 4), d);
         nTests++;
         if (d !== exp0) begin
            nFail++;
            $display("FAIL reset rd addr=%0d got %h exp %h",
                     a * 4, d, exp0);
         end
      end
      nTests++;
      if (IRQ !== 1'b0) begin
         nFail++;
         $display("FAIL reset irq got %b exp 0", IRQ);
      end
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      doReset();
      wrReg(4'h4, 32'd3);
      wrReg(4'h0, 32'h9);
      track("oneshot", 3, 0, 1'b1, 0, 6);
      readReg(4'h0, d);
      nTests++;
      if (d !== 32'h8) begin
         nFail++;
         $display("FAIL oneshot ctrl got %h exp 8", d);
      end
      step();
      nTests++;
      if (IRQ !== 1'b1) begin
         nFail++;
         $display("FAIL oneshot irq hold got %b exp 1", IRQ);
      end
      wrReg(4'h0, 32'h8);
      nTests++;
      if (IRQ !== 1'b0) begin
         nFail++;
         $display("FAIL oneshot irq clear got %b exp 0", IRQ);
      end
   endtask

   task automatic test_reload();
      int highs;
      doReset();
      wrReg(4'h4, 32'd2);
      wrReg(4'h0, 32'hB);
      highs = 0;
      for (int k = 1; k <= 12; k++) begin
         step();
         if (IRQ === 1'b1) highs++;
      end
      nTests++;
      if (highs != 3) begin
         nFail++;
         $display("FAIL reload pulses got %0d exp 3", highs);
      end
      doReset();
      wrReg(4'h4, 32'd2);
      wrReg(4'h0, 32'hB);
      track("reload", 2, 1, 1'b1, 0, 13);
   endtask

   task automatic test_masked();
      doReset();
      wrReg(4'h4, 32'd2);
      wrReg(4'h0, 32'h1);
      track("masked", 2, 0, 1'b0, 0, 6);
      wrReg(4'h0, 32'h8);
      nTests++;
      if (IRQ !== 1'b0) begin
         nFail++;
         $display("FAIL masked irq after unmask got %b exp 0", IRQ);
      end
   endtask

   task automatic test_midcount();
      logic [31:0] d;
      doReset();
      wrReg(4'h4, 32'd10);
      wrReg(4'h0, 32'h1);
      track("midcount", 10, 0, 1'b0, 0, 6);
      wrReg(4'h0, 32'h0);
      step();
      step();
      readReg(4'h8, d);
      nTests++;
      if (d !== 32'd5) begin
         nFail++;
         $display("FAIL midcount freeze got %0d exp 5", d);
      end
      wrReg(4'h4, 32'd4);
      step();
      readReg(4'h8, d);
      nTests++;
      if (d !== 32'd5) begin
         nFail++;
         $display("FAIL midcount preset got %0d exp 5", d);
      end
      wrReg(4'h0, 32'h1);
      track("midcount_re", 4, 0, 1'b0, 5, 3);
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      doReset();
      wrReg(4'h4, 32'd9);
      wrReg(4'h0, 32'hB);
      track("arst_pre", 9, 1, 1'b1, 0, 4);
      rst_n = 1'b0;
      for (int a = 0; a < 3; a++) begin
         readReg(4'(a * 4), d);
         nTests++;
         if (d !== 32'd0) begin
            nFail++;
            $display("FAIL arst rd addr=%0d got %h exp 0", a * 4, d);
         end
      end
      nTests++;
      if (IRQ !== 1'b0) begin
         nFail++;
         $display("FAIL arst irq got %b exp 0", IRQ);
      end
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) step();
      readReg(4'h8, d);
      nTests++;
      if (d !== 32'd0) begin
         nFail++;
         $display("FAIL arst idle count got %0d exp 0", d);
      end
   endtask

   task automatic test_random();
      int n;
      int md;
      bit im;
      int eff;
      int cyc;
      logic [31:0] d;
      logic [31:0] expCtrl;
      for (int t = 0; t < 12; t++) begin
         doReset();
         n   = int'($urandom_range(0, 6));
         md  = int'($urandom_range(0, 3));
         im  = 1'($urandom_range(0, 1));
         eff = (n < 1) ? 1 : n;
         cyc = (md == 1) ? 3 * (eff + 2) : eff + 5;
         wrReg(4'h4, 32'(n));
         wrReg(4'h0, 32'({im, 2'(md), 1'b1}));
         track("random", n, md, im, 0, cyc);
         readReg(4'h0, d);
         expCtrl = 32'({im, 2'(md), md == 1});
         nTests++;
         if (d !== expCtrl) begin
            nFail++;
            $display("FAIL random ctrl t=%0d got %h exp %h",
                     t, d, expCtrl);
         end
      end
   endtask

   initial begin
      nTests = 0;
      nFail  = 0;
      rst_n  = 1'b1;
      We     = 1'b0;
      Addr   = 4'h0;
      WD     = '0;
      #2;
      test_reset();
      test_oneshot();
      test_reload();
      test_masked();
      test_midcount();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
